// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter feeding a shared bitwise logic unit.
// The result lands in a single-entry register that drives a valid/ready response channel.
//
// state   | meaning
// S_EMPTY | result register empty, rsp_valid=0
// S_FULL  | result register holds an unconsumed result, rsp_valid=1
module bitwise_unit_arbiter #(
   parameter int N  = 8,
   parameter int R  = 4,
   localparam int IW = $clog2(R)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [R-1:0]      req_valid,
   output logic [R-1:0]      req_ready,
   input  logic [3*R-1:0]    req_op,
   input  logic [N*R-1:0]    req_a,
   input  logic [N*R-1:0]    req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [N-1:0]      rsp_c,
   output logic [IW-1:0]     rsp_id,
   output logic [2:0]        rsp_op
);

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [N-1:0]    rsp_c_q, rsp_c_d;
   logic [IW-1:0]   rsp_id_q, rsp_id_d;
   logic [2:0]      rsp_op_q, rsp_op_d;

   logic            can_accept;
   logic            found;
   logic            grant;
   logic [IW-1:0]   gnt_idx;
   logic [2:0]      op_sel;
   logic [N-1:0]    a_sel, b_sel, result;

   // Scan from ptr upward with wrap; only req_valid feeds the search, never the payload.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < R; k++) begin
         if (!found && req_valid[(int'(ptr_q) + k) % R]) begin
            found   = 1'b1;
            gnt_idx = IW'((int'(ptr_q) + k) % R);
         end
      end
   end

   always_comb begin
      can_accept = (state_q == S_EMPTY) || rsp_ready;
      grant      = can_accept && found && !rst;
      req_ready  = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      op_sel = req_op[3*gnt_idx +: 3];
      a_sel  = req_a[N*gnt_idx +: N];
      b_sel  = req_b[N*gnt_idx +: N];
      case (op_sel)
         3'b000:  result = ~a_sel;
         3'b001:  result = a_sel & b_sel;
         3'b010:  result = a_sel | b_sel;
         3'b011:  result = a_sel ^ b_sel;
         3'b100:  result = ~(a_sel & b_sel);
         3'b101:  result = ~(a_sel | b_sel);
         3'b110:  result = ~(a_sel ^ b_sel);
         default: result = a_sel;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      rsp_c_d  = rsp_c_q;
      rsp_id_d = rsp_id_q;
      rsp_op_d = rsp_op_q;
      if (grant) begin
         state_d  = S_FULL;
         ptr_d    = (gnt_idx == IW'(R-1)) ? '0 : gnt_idx + 1'b1;
         rsp_c_d  = result;
         rsp_id_d = gnt_idx;
         rsp_op_d = op_sel;
      end else if (state_q == S_FULL && rsp_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_EMPTY;
         ptr_q    <= '0;
         rsp_c_q  <= '0;
         rsp_id_q <= '0;
         rsp_op_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rsp_c_q  <= rsp_c_d;
         rsp_id_q <= rsp_id_d;
         rsp_op_q <= rsp_op_d;
      end
   end

   assign rsp_valid = (state_q == S_FULL);
   assign rsp_c     = rsp_c_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed bench for bitwise_unit_arbiter: a vector table for steady traffic
// plus hand-written backpressure and mid-operation reset sequences.
module tb_bitwise_unit_arbiter;

   localparam int N = 8;
   localparam int R = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [11:0]   req_op = '0;
   logic [31:0]   req_a = '0;
   logic [31:0]   req_b = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [7:0]    rsp_c;
   logic [1:0]    rsp_id;
   logic [2:0]    rsp_op;

   int total = 0;
   int bad   = 0;

   bitwise_unit_arbiter #(.N(N), .R(R)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_c(rsp_c), .rsp_id(rsp_id), .rsp_op(rsp_op)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [11:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic        rrdy;
      logic [3:0]  exp_rdy;
      logic        exp_v;
      logic [7:0]  exp_c;
      logic [1:0]  exp_id;
      logic [2:0]  exp_op;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic [3:0] valid, input logic [11:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rrdy, input logic [3:0] exp_rdy,
                          input logic exp_v, input logic [7:0] exp_c, input logic [1:0] exp_id,
                          input logic [2:0] exp_op);
      vec_t v;
      v.valid = valid; v.op = op; v.a = a; v.b = b; v.rrdy = rrdy;
      v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.exp_c = exp_c; v.exp_id = exp_id; v.exp_op = exp_op;
      vq.push_back(v);
   endtask

   task automatic drive(input logic [3:0] valid, input logic [11:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic rrdy);
      req_valid = valid; req_op = op; req_a = a; req_b = b; rsp_ready = rrdy;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [7:0] c,
                          input logic [1:0] id, input logic [2:0] op);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v));
      if (v) begin
         chk({tag, " rsp_c"},  32'(rsp_c),  32'(c));
         chk({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
         chk({tag, " rsp_op"}, 32'(rsp_op), 32'(op));
      end
   endtask

   logic [11:0] rr_op;
   logic [31:0] rr_a;
   logic [7:0]  rr_c [4];

   initial begin
      rr_op = {3'b011, 3'b011, 3'b011, 3'b011};
      rr_a  = {8'h40, 8'h30, 8'h20, 8'h10};
      rr_c[0] = 8'h1F; rr_c[1] = 8'h2F; rr_c[2] = 8'h3F; rr_c[3] = 8'h4F;

      // single NOT from requester 2
      add_vec(4'b0100, {3'b000, 3'b000, 3'b000, 3'b000}, 32'h00A5_0000, '0, 1'b1,
              4'b0100, 1'b1, 8'h5A, 2'd2, 3'b000);
      // every opcode from requester 0, back to back
      begin
         logic [7:0] ops_res [8];
         ops_res = '{8'h33, 8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC};
         for (int k = 0; k < 8; k++)
            add_vec(4'b0001, {9'b0, 3'(k)}, 32'h0000_00CC, 32'h0000_00AA, 1'b1,
                    4'b0001, 1'b1, ops_res[k], 2'd0, 3'(k));
      end
      add_vec(4'b0000, '0, '0, '0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 3'b000);
      // pass-through from requester 3 moves ptr back to 0
      add_vec(4'b1000, {3'b111, 9'b0}, 32'h5C00_0000, '0, 1'b1,
              4'b1000, 1'b1, 8'h5C, 2'd3, 3'b111);
      // round robin: 0,1,2,3,0,1 then requester 1 dropped: 2,3,0,2,3,0
      for (int k = 0; k < 6; k++)
         add_vec(4'b1111, rr_op, rr_a, 32'h0F0F_0F0F, 1'b1,
                 4'(1 << (k % 4)), 1'b1, rr_c[k % 4], 2'(k % 4), 3'b011);
      begin
         int seq [6];
         seq = '{2, 3, 0, 2, 3, 0};
         for (int k = 0; k < 6; k++)
            add_vec(4'b1101, rr_op, rr_a, 32'h0F0F_0F0F, 1'b1,
                    4'(1 << seq[k]), 1'b1, rr_c[seq[k]], 2'(seq[k]), 3'b011);
      end
      add_vec(4'b0000, '0, '0, '0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 3'b000);

      // reset held from time 0
      #2;
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_c", 32'(rsp_c), 32'd0);
      chk("reset rsp_id", 32'(rsp_id), 32'd0);
      req_valid = 4'b1111;
      #1;
      chk("reset req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b0;

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].valid, vq[i].op, vq[i].a, vq[i].b, vq[i].rrdy);
         #1;
         chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vq[i].exp_rdy));
         @(posedge clk);
         #1;
         chk_rsp($sformatf("vec%0d", i), vq[i].exp_v, vq[i].exp_c, vq[i].exp_id, vq[i].exp_op);
      end

      // backpressure: EMPTY, ptr=1, requesters 0 and 2 valid
      @(negedge clk);
      drive(4'b0101, {3'b000, 3'b010, 3'b000, 3'b001}, 32'h00F0_00F0, 32'h000F_003C, 1'b0);
      #1;
      chk("bp first grant", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      chk_rsp("bp fill", 1'b1, 8'hFF, 2'd2, 3'b010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         chk("bp stall req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         chk_rsp("bp stall", 1'b1, 8'hFF, 2'd2, 3'b010);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bp drain+grant req_ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      chk_rsp("bp refill", 1'b1, 8'h30, 2'd0, 3'b001);
      @(negedge clk);
      drive('0, '0, '0, '0, 1'b1);
      @(posedge clk); #1;
      chk_rsp("bp drain", 1'b0, 8'h00, 2'd0, 3'b000);

      // reset while FULL with ptr=3
      @(negedge clk);
      drive(4'b0100, {3'b000, 3'b001, 6'b0}, 32'h0033_0000, 32'h0011_0000, 1'b0);
      @(posedge clk); #1;
      chk_rsp("pre-reset fill", 1'b1, 8'h11, 2'd2, 3'b001);
      drive(4'b1111, rr_op, rr_a, 32'h0F0F_0F0F, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async rst rsp_c", 32'(rsp_c), 32'd0);
      chk("async rst rsp_op", 32'(rsp_op), 32'd0);
      chk("async rst req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("held rst req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk($sformatf("post-rst grant%0d", k), 32'(req_ready), 32'(1 << k));
         @(posedge clk); #1;
         chk_rsp($sformatf("post-rst rsp%0d", k), 1'b1, rr_c[k], 2'(k), 3'b011);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
